// File: rtl/mandelbrot_pkg.sv
// Shared FSM encoding, default widths and a counter-width helper for the frame sequencer.
package mandelbrot_pkg;

  localparam int DEF_COORD_W = 12;
  localparam int DEF_ITER_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_WAIT,
    S_FLUSH,
    S_DONE
  } seq_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mandelbrot_frame_sequencer_if.sv
// Sequencer-facing bundle: frame control, iteration-core handshake, pixel-memory write port, status.
// The optional abort input exists only when SEQ_ABORT_EN is defined.
interface mandelbrot_frame_sequencer_if #(
  parameter int COORD_W = 12,
  parameter int ITER_W  = 4
);
  logic               start;
  logic [COORD_W-1:0] re_start;
  logic [COORD_W-1:0] im_start;
  logic [COORD_W-1:0] step;
  logic               core_start;
  logic [COORD_W-1:0] core_cr;
  logic [COORD_W-1:0] core_ci;
  logic               core_done;
  logic [ITER_W-1:0]  core_iter;
  logic               mem_reset_write_ptr;
  logic               mem_write;
  logic [ITER_W-1:0]  mem_write_data;
  logic               running;
  logic               finished;
`ifdef SEQ_ABORT_EN
  logic               abort;
`endif

  modport master (
    input  start, re_start, im_start, step, core_done, core_iter,
    output core_start, core_cr, core_ci, mem_reset_write_ptr, mem_write, mem_write_data,
    output running, finished
`ifdef SEQ_ABORT_EN
    , input abort
`endif
  );

  modport slave (
    output start, re_start, im_start, step, core_done, core_iter,
    input  core_start, core_cr, core_ci, mem_reset_write_ptr, mem_write, mem_write_data,
    input  running, finished
`ifdef SEQ_ABORT_EN
    , output abort
`endif
  );

endinterface

// File: rtl/seq_result_fifo.sv
// Two-entry result FIFO; head is visible combinationally, push and pop may share a cycle even when full.
// Pushing while full without a pop is not guarded: the sequencer never issues a pixel into a full FIFO.
module seq_result_fifo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      // When full, the write slot is the head being popped this same cycle.
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/mandelbrot_frame_sequencer.sv
// Walks one frame row-major through the iteration core and streams counts to pixel memory, writes spaced >= WR_GAP.
// start -> mem_reset_write_ptr next cycle -> first core_start one cycle later; SEQ_ABORT_EN adds a frame abort.
module mandelbrot_frame_sequencer
  import mandelbrot_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int ROWS    = 60,
  parameter int COORD_W = DEF_COORD_W,
  parameter int ITER_W  = DEF_ITER_W,
  parameter int WR_GAP  = 2
) (
  input logic                      clk,
  input logic                      reset,
  mandelbrot_frame_sequencer_if.master bus
);

  localparam int X_W   = cnt_w(COLS);
  localparam int Y_W   = cnt_w(ROWS);
  localparam int GAP_W = cnt_w(WR_GAP);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(ROWS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP - 1);

  seq_state_e         state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COORD_W-1:0] cr_q, cr_d;
  logic [COORD_W-1:0] ci_q, ci_d;
  logic [COORD_W-1:0] re0_q, re0_d;
  logic [COORD_W-1:0] step_q, step_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic              abort;
  logic              start_ok;
  logic              done_ok;
  logic              last_px;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ITER_W-1:0] fifo_head;

`ifdef SEQ_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  assign start_ok = bus.start && !abort && (state_q == S_IDLE || state_q == S_DONE);
  assign done_ok  = bus.core_done && (state_q == S_WAIT) && !abort;
  assign last_px  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign pop      = !fifo_empty && (gap_q == '0) && !abort;

  seq_result_fifo #(.W(ITER_W)) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .flush_i    (abort),
    .push_i     (done_ok),
    .push_dat_i (bus.core_iter),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      re0_q   <= '0;
      step_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      re0_q   <= re0_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_CLR;
      S_CLR:          state_d = S_ISSUE;
      S_ISSUE:        if (!fifo_full) state_d = S_WAIT;
      S_WAIT:         if (done_ok) state_d = last_px ? S_FLUSH : S_ISSUE;
      S_FLUSH:        if (fifo_empty && gap_q == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    bus.core_start          = 1'b0;
    bus.mem_reset_write_ptr = 1'b0;
    bus.running             = 1'b0;
    bus.finished            = 1'b0;
    case (state_q)
      S_CLR: begin
        bus.mem_reset_write_ptr = 1'b1;
        bus.running             = 1'b1;
      end
      S_ISSUE: begin
        bus.running    = 1'b1;
        bus.core_start = !fifo_full && !abort;
      end
      S_WAIT, S_FLUSH: bus.running  = 1'b1;
      S_DONE:          bus.finished = 1'b1;
      default: ;
    endcase
  end

  // Pixel walk: columns step right by +step, rows step down by -step.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cr_d   = cr_q;
    ci_d   = ci_q;
    re0_d  = re0_q;
    step_d = step_q;
    if (start_ok) begin
      x_d    = '0;
      y_d    = '0;
      cr_d   = bus.re_start;
      ci_d   = bus.im_start;
      re0_d  = bus.re_start;
      step_d = bus.step;
    end else if (done_ok && !last_px) begin
      if (x_q == X_LAST) begin
        x_d  = '0;
        y_d  = y_q + Y_W'(1);
        cr_d = re0_q;
        ci_d = ci_q - step_q;
      end else begin
        x_d  = x_q + X_W'(1);
        cr_d = cr_q + step_q;
      end
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (abort)              gap_d = '0;
    else if (pop)           gap_d = GAP_LOAD;
    else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);
  end

  assign bus.core_cr        = cr_q;
  assign bus.core_ci        = ci_q;
  assign bus.mem_write      = pop;
  assign bus.mem_write_data = pop ? fifo_head : '0;

endmodule

// File: tb/tb_mandelbrot_frame_sequencer.sv
// Bench for mandelbrot_frame_sequencer: a pixel-index reference model plus a second instance for write pacing.
module tb_mandelbrot_frame_sequencer;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int NPIX = COLS * ROWS;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  int n_chk  = 0;
  int n_fail = 0;

  mandelbrot_frame_sequencer_if #(.COORD_W(12), .ITER_W(4)) bus ();
  mandelbrot_frame_sequencer_if #(.COORD_W(12), .ITER_W(4)) bus4 ();

  mandelbrot_frame_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .COORD_W(12), .ITER_W(4), .WR_GAP(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mandelbrot_frame_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .COORD_W(12), .ITER_W(4), .WR_GAP(4)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state for the WR_GAP=2 instance.
  logic [11:0] re_m, im_m, st_m;
  int          k = 0;
  int          lat = 3;
  bit          idx_mode = 1'b1;
  logic [3:0]  exp_q[$];
  int          cd = 0;
  logic [3:0]  pend = '0;
  int          frame_wr = 0;
  int          last_wr = 0;
  int          rp_cnt = 0;
  int          rp_want = 0;
  bit          frame_open = 1'b0;

  // Reference model state for the WR_GAP=4 instance.
  logic [3:0]  exp4_q[$];
  int          cd4 = 0;
  logic [3:0]  pend4 = '0;
  int          wr4 = 0;
  int          last4 = 0;
  int          cs4_last = -1;
  int          max_sp4 = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Iteration core model: answers each core_start after 'lat' cycles.
  initial forever begin
    @(negedge clk);
    bus.core_done = 1'b0;
    if (reset) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.core_done = 1'b1;
          bus.core_iter = pend;
          exp_q.push_back(pend);
        end
      end
      if (bus.core_start) begin
        check_eq("core_in_frame", k < NPIX, 1);
        check_eq("core_cr", bus.core_cr, 12'(re_m + (k % COLS) * st_m));
        check_eq("core_ci", bus.core_ci, 12'(im_m - (k / COLS) * st_m));
        pend = idx_mode ? 4'(k) : 4'($urandom);
        k++;
        cd = lat;
      end
    end
  end

  // Pixel memory model for the WR_GAP=2 instance.
  initial forever begin
    @(negedge clk);
    if (bus.mem_reset_write_ptr) begin
      rp_cnt++;
      frame_open = 1'b1;
    end
    if (bus.mem_write) begin
      check_eq("wr_after_rptr", frame_open, 1);
      check_eq("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("wr_data", bus.mem_write_data, exp_q.pop_front());
      if (frame_wr > 0) check_eq("wr_gap_min", (cyc - last_wr) >= 2, 1);
      frame_wr++;
      last_wr = cyc;
    end
  end

  // Core model (1-cycle latency) and memory model for the WR_GAP=4 instance.
  initial forever begin
    @(negedge clk);
    bus4.core_done = 1'b0;
    if (reset) begin
      cd4 = 0;
    end else begin
      if (cd4 > 0) begin
        cd4--;
        if (cd4 == 0) begin
          bus4.core_done = 1'b1;
          bus4.core_iter = pend4;
          exp4_q.push_back(pend4);
        end
      end
      if (bus4.core_start) begin
        if (cs4_last >= 0 && (cyc - cs4_last) > max_sp4) max_sp4 = cyc - cs4_last;
        cs4_last = cyc;
        pend4 = 4'($urandom);
        cd4 = 1;
      end
      if (bus4.mem_write) begin
        check_eq("wr4_expected", exp4_q.size() > 0, 1);
        if (exp4_q.size() > 0) check_eq("wr4_data", bus4.mem_write_data, exp4_q.pop_front());
        if (wr4 > 0) check_eq("wr4_gap_exact", cyc - last4, 4);
        wr4++;
        last4 = cyc;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_core_start"}, bus.core_start, 0);
    check_eq({tag, "_core_cr"}, bus.core_cr, 0);
    check_eq({tag, "_core_ci"}, bus.core_ci, 0);
    check_eq({tag, "_rptr"}, bus.mem_reset_write_ptr, 0);
    check_eq({tag, "_mem_write"}, bus.mem_write, 0);
    check_eq({tag, "_mem_data"}, bus.mem_write_data, 0);
    check_eq({tag, "_running"}, bus.running, 0);
    check_eq({tag, "_finished"}, bus.finished, 0);
  endtask

  task automatic start_frame(input logic [11:0] re, input logic [11:0] im, input logic [11:0] st);
    @(negedge clk);
    re_m = re; im_m = im; st_m = st;
    k = 0; frame_wr = 0; frame_open = 1'b0;
    rp_want++;
    bus.re_start = re; bus.im_start = im; bus.step = st;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("lat_rptr", bus.mem_reset_write_ptr, 1);
    check_eq("lat_running", bus.running, 1);
    check_eq("lat_finished_drop", bus.finished, 0);
    check_eq("lat_no_early_core", bus.core_start, 0);
    @(negedge clk);
    check_eq("lat_first_core", bus.core_start, 1);
  endtask

  task automatic check_frame_end(input string tag);
    int t = 0;
    while (!bus.finished && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_finished"}, bus.finished, 1);
    check_eq({tag, "_writes"}, frame_wr, NPIX);
    check_eq({tag, "_pixels"}, k, NPIX);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    check_eq({tag, "_running"}, bus.running, 0);
    check_eq({tag, "_rptr_cnt"}, rp_cnt, rp_want);
  endtask

  initial begin
    int t;
    int wr_at;
    int k_at;
    reset = 1'b1;
    bus.start = 1'b0; bus.re_start = '0; bus.im_start = '0; bus.step = '0;
    bus.core_done = 1'b0; bus.core_iter = '0;
    bus4.start = 1'b0; bus4.re_start = '0; bus4.im_start = '0; bus4.step = '0;
    bus4.core_done = 1'b0; bus4.core_iter = '0;
`ifdef SEQ_ABORT_EN
    bus.abort = 1'b0;
    bus4.abort = 1'b0;
`endif

    // Reset state, with start held during reset.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus4.start = 1'b1;
    @(negedge clk);
    check_reset_outs("rst");
    bus.start = 1'b0;
    bus4.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_start_ignored_running", bus.running, 0);
    check_eq("rst_start_ignored_rptr", rp_cnt, 0);

    // Directed frame: iteration = pixel index, 3-cycle core.
    lat = 3; idx_mode = 1'b1;
    start_frame(12'hFF8, 12'd4, 12'd2);
    check_frame_end("dir");

    // Restart from DONE, then a start while running.
    lat = 2; idx_mode = 1'b0;
    start_frame(12'($urandom), 12'($urandom), 12'($urandom));
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("busy_start_no_rptr", bus.mem_reset_write_ptr, 0);
    check_frame_end("busy");

    // Random frames with random core latency.
    for (int i = 0; i < 3; i++) begin
      lat = $urandom_range(1, 5);
      start_frame(12'($urandom), 12'($urandom), 12'($urandom));
      check_frame_end("rnd");
    end

    // Reset after the third write of a frame.
    lat = 2;
    start_frame(12'($urandom), 12'($urandom), 12'($urandom));
    t = 0;
    while (frame_wr < 3 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check_eq("mid_third_write", frame_wr, 3);
    #1;
    reset = 1'b1;
    exp_q.delete();
    k = 0;
    frame_open = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_frame(12'($urandom), 12'($urandom), 12'($urandom));
    check_frame_end("post_rst");

    // WR_GAP=4 instance with a 1-cycle core: FIFO fills and issue stalls.
    @(negedge clk);
    bus4.re_start = 12'($urandom); bus4.im_start = 12'($urandom); bus4.step = 12'($urandom);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    check_eq("gap4_rptr", bus4.mem_reset_write_ptr, 1);
    t = 0;
    while (!bus4.finished && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("gap4_finished", bus4.finished, 1);
    check_eq("gap4_writes", wr4, NPIX);
    check_eq("gap4_drained", exp4_q.size(), 0);
    check_eq("gap4_issue_stalled", max_sp4 > 2, 1);

`ifdef SEQ_ABORT_EN
    // Abort while waiting on the core.
    lat = 3;
    start_frame(12'($urandom), 12'($urandom), 12'($urandom));
    t = 0;
    while (!(bus.core_start && frame_wr >= 2) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("abort_reached_issue", bus.core_start, 1);
    @(negedge clk);
    #1;
    bus.abort = 1'b1;
    wr_at = frame_wr;
    k_at = k;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_running", bus.running, 0);
    check_eq("abort_finished", bus.finished, 0);
    repeat (20) @(negedge clk);
    check_eq("abort_no_more_writes", frame_wr, wr_at);
    check_eq("abort_no_more_issue", k, k_at);
    check_eq("abort_idle_running", bus.running, 0);
    exp_q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
